// File: rtl/mem_dual_issue_sched.sv
// Dual-lane memory issue scheduler: passes two lane requests to a dual-port datamem
// and serializes same-word pairs involving a store by replaying lane B one cycle later.
module mem_dual_issue_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  reqA_valid,
  input  logic                  reqB_valid,
  input  logic                  reqA_write,
  input  logic                  reqB_write,
  input  logic [DATA_WIDTH-1:0] reqA_addr,
  input  logic [DATA_WIDTH-1:0] reqB_addr,
  input  logic [DATA_WIDTH-1:0] reqA_wdata,
  input  logic [DATA_WIDTH-1:0] reqB_wdata,
  output logic [1:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_addrA,
  output logic [DATA_WIDTH-1:0] mem_addrB,
  output logic [DATA_WIDTH-1:0] mem_wdataA,
  output logic [DATA_WIDTH-1:0] mem_wdataB,
  output logic                  portA_rd,
  output logic                  portB_rd,
  output logic                  stall,
  output logic                  replay_B,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  typedef enum logic {ISSUE = 1'b0, REPLAY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  hold_write_q;
  logic [DATA_WIDTH-1:0] hold_addr_q;
  logic [DATA_WIDTH-1:0] hold_wdata_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  conflict;
  logic                  capture;

  // Word granularity: byte offset bits are ignored; two loads never conflict.
  assign conflict = reqA_valid & reqB_valid &
                    (reqA_addr[DATA_WIDTH-1:2] == reqB_addr[DATA_WIDTH-1:2]) &
                    (reqA_write | reqB_write);

  assign capture      = (state_q == ISSUE) & conflict & ~flush;
  assign conflict_cnt = cnt_q;

  always_comb begin
    state_d    = state_q;
    mem_we     = 2'b00;
    mem_addrA  = '0;
    mem_addrB  = '0;
    mem_wdataA = '0;
    mem_wdataB = '0;
    portA_rd   = 1'b0;
    portB_rd   = 1'b0;
    stall      = 1'b0;
    replay_B   = 1'b0;
    if (!rst) begin
      case (state_q)
        ISSUE: begin
          if (!flush) begin
            if (reqA_valid) begin
              mem_we[1]  = reqA_write;
              mem_addrA  = reqA_addr;
              mem_wdataA = reqA_wdata;
              portA_rd   = ~reqA_write;
            end
            if (conflict) begin
              stall   = 1'b1;
              state_d = REPLAY;
            end else if (reqB_valid) begin
              mem_we[0]  = reqB_write;
              mem_addrB  = reqB_addr;
              mem_wdataB = reqB_wdata;
              portB_rd   = ~reqB_write;
            end
          end
        end
        REPLAY: begin
          state_d = ISSUE;
          // Live inputs are ignored here; only the captured lane-B request issues.
          if (!flush) begin
            mem_we[0]  = hold_write_q;
            mem_addrB  = hold_addr_q;
            mem_wdataB = hold_wdata_q;
            portB_rd   = ~hold_write_q;
            replay_B   = 1'b1;
          end
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ISSUE;
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        hold_write_q <= reqB_write;
        hold_addr_q  <= reqB_addr;
        hold_wdata_q <= reqB_wdata;
        if (cnt_q != {CNT_WIDTH{1'b1}}) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_dual_issue_sched.sv
// Directed bench for mem_dual_issue_sched: vector table plus flush, async-reset
// and counter-saturation sequences.
module tb_mem_dual_issue_sched;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          reqA_valid, reqB_valid, reqA_write, reqB_write;
  logic [DW-1:0] reqA_addr, reqB_addr, reqA_wdata, reqB_wdata;
  logic [1:0]    mem_we;
  logic [DW-1:0] mem_addrA, mem_addrB, mem_wdataA, mem_wdataB;
  logic          portA_rd, portB_rd, stall, replay_B;
  logic [CW-1:0] conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mem_dual_issue_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .reqA_valid(reqA_valid), .reqB_valid(reqB_valid),
    .reqA_write(reqA_write), .reqB_write(reqB_write),
    .reqA_addr(reqA_addr), .reqB_addr(reqB_addr),
    .reqA_wdata(reqA_wdata), .reqB_wdata(reqB_wdata),
    .mem_we(mem_we), .mem_addrA(mem_addrA), .mem_addrB(mem_addrB),
    .mem_wdataA(mem_wdataA), .mem_wdataB(mem_wdataB),
    .portA_rd(portA_rd), .portB_rd(portB_rd),
    .stall(stall), .replay_B(replay_B), .conflict_cnt(conflict_cnt)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic          a_v, a_w;
    logic [DW-1:0] a_addr, a_wd;
    logic          b_v, b_w;
    logic [DW-1:0] b_addr, b_wd;
    logic          fl;
    logic [1:0]    we;
    logic [DW-1:0] addrA, wdA, addrB, wdB;
    logic          rdA, rdB, stl;
    logic [1:0]    r_we;
    logic [DW-1:0] r_addrB, r_wdB;
    logic          r_rdB;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ports(input string tag, input logic [1:0] we,
                           input logic [DW-1:0] aA, input logic [DW-1:0] wA,
                           input logic [DW-1:0] aB, input logic [DW-1:0] wB,
                           input logic rA, input logic rB, input logic st, input logic rp);
    chk({tag, ".mem_we"},     64'(mem_we),     64'(we));
    chk({tag, ".mem_addrA"},  64'(mem_addrA),  64'(aA));
    chk({tag, ".mem_wdataA"}, 64'(mem_wdataA), 64'(wA));
    chk({tag, ".mem_addrB"},  64'(mem_addrB),  64'(aB));
    chk({tag, ".mem_wdataB"}, 64'(mem_wdataB), 64'(wB));
    chk({tag, ".portA_rd"},   64'(portA_rd),   64'(rA));
    chk({tag, ".portB_rd"},   64'(portB_rd),   64'(rB));
    chk({tag, ".stall"},      64'(stall),      64'(st));
    chk({tag, ".replay_B"},   64'(replay_B),   64'(rp));
  endtask

  task automatic drive(input logic av, input logic aw, input logic [DW-1:0] aa,
                       input logic [DW-1:0] ad, input logic bv, input logic bw,
                       input logic [DW-1:0] ba, input logic [DW-1:0] bd, input logic fl);
    reqA_valid = av; reqA_write = aw; reqA_addr = aa; reqA_wdata = ad;
    reqB_valid = bv; reqB_write = bw; reqB_addr = ba; reqB_wdata = bd;
    flush = fl;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Conflicting live traffic used while the block must ignore its inputs.
  task automatic drive_noise();
    drive(1'b1, 1'b1, 32'h999, 32'hDEAD, 1'b1, 1'b1, 32'h998, 32'hBEEF, 1'b0);
  endtask

  task automatic drive_conflict();
    drive(1'b1, 1'b1, 32'h100, 32'h11, 1'b1, 1'b1, 32'h102, 32'h22, 1'b0);
  endtask

  initial begin
    // a_v a_w a_addr a_wd | b_v b_w b_addr b_wd | fl | we addrA wdA addrB wdB rdA rdB stall | r_we r_addrB r_wdB r_rdB | cnt
    vecs[0] = '{1,1,32'h100,32'hAA, 1,0,32'h200,32'h0, 0, 2'b10,32'h100,32'hAA,32'h200,32'h0,0,1,0, 2'b00,32'h0,32'h0,0, 4'd0};
    vecs[1] = '{1,0,32'h40,32'h0,   1,0,32'h40,32'h0,  0, 2'b00,32'h40,32'h0,32'h40,32'h0,1,1,0,    2'b00,32'h0,32'h0,0, 4'd0};
    vecs[2] = '{1,1,32'h10,32'h5,   0,1,32'h10,32'h7,  0, 2'b10,32'h10,32'h5,32'h0,32'h0,0,0,0,     2'b00,32'h0,32'h0,0, 4'd0};
    vecs[3] = '{1,1,32'h100,32'h11, 1,1,32'h102,32'h22,1, 2'b00,32'h0,32'h0,32'h0,32'h0,0,0,0,      2'b00,32'h0,32'h0,0, 4'd0};
    vecs[4] = '{1,1,32'h100,32'h11, 1,1,32'h102,32'h22,0, 2'b10,32'h100,32'h11,32'h0,32'h0,0,0,1,   2'b01,32'h102,32'h22,0, 4'd1};
    vecs[5] = '{1,0,32'h204,32'h0,  1,1,32'h207,32'h55,0, 2'b00,32'h204,32'h0,32'h0,32'h0,1,0,1,    2'b01,32'h207,32'h55,0, 4'd2};
    vecs[6] = '{1,1,32'h300,32'h1,  1,0,32'h303,32'h0, 0, 2'b10,32'h300,32'h1,32'h0,32'h0,0,0,1,    2'b00,32'h303,32'h0,1, 4'd3};
    vecs[7] = '{1,1,32'h100,32'h1,  1,1,32'h104,32'h2, 0, 2'b11,32'h100,32'h1,32'h104,32'h2,0,0,0,  2'b00,32'h0,32'h0,0, 4'd3};
    vecs[8] = '{0,0,32'h0,32'h0,    1,1,32'h500,32'h9, 0, 2'b01,32'h0,32'h0,32'h500,32'h9,0,0,0,    2'b00,32'h0,32'h0,0, 4'd3};

    // Reset with conflicting live inputs: every output must read zero.
    rst = 1'b1;
    drive_conflict();
    @(negedge clk); #1;
    chk_ports("reset", 2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].a_v, vecs[i].a_w, vecs[i].a_addr, vecs[i].a_wd,
            vecs[i].b_v, vecs[i].b_w, vecs[i].b_addr, vecs[i].b_wd, vecs[i].fl);
      #1;
      chk_ports($sformatf("v%0d", i), vecs[i].we, vecs[i].addrA, vecs[i].wdA,
                vecs[i].addrB, vecs[i].wdB, vecs[i].rdA, vecs[i].rdB, vecs[i].stl, 1'b0);
      if (vecs[i].stl) begin
        @(negedge clk);
        drive_noise();
        #1;
        chk_ports($sformatf("v%0d.replay", i), vecs[i].r_we, '0, '0,
                  vecs[i].r_addrB, vecs[i].r_wdB, 1'b0, vecs[i].r_rdB, 1'b0, 1'b1);
      end
      @(negedge clk);
      drive_idle();
      #1;
      chk($sformatf("v%0d.cnt", i), 64'(conflict_cnt), 64'(vecs[i].cnt));
      $display("[TB] vector %0d done", i);
    end

    // Flush in the replay cycle cancels the deferred B; next cycle is a normal issue.
    @(negedge clk);
    drive_conflict();
    #1;
    chk("flush.issue_stall", 64'(stall), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h100, 32'h11, 1'b1, 1'b1, 32'h102, 32'h22, 1'b1);
    #1;
    chk_ports("flush.replay", 2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h80, 32'h66, 1'b0);
    #1;
    chk_ports("flush.next", 2'b01, 32'h40, 32'h0, 32'h80, 32'h66, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush.cnt", 64'(conflict_cnt), 64'd4);
    $display("[TB] flush-in-replay sequence done");

    // Asynchronous reset in the middle of a replay cycle.
    @(negedge clk);
    drive_conflict();
    @(negedge clk);
    drive_idle();
    #1;
    chk("arst.pre_replay", 64'(replay_B), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk_ports("arst.during", 2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst.cnt", 64'(conflict_cnt), 64'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk_ports($sformatf("arst.after%0d", k), 2'b00, '0, '0, '0, '0,
                1'b0, 1'b0, 1'b0, 1'b0);
    end
    $display("[TB] async-reset-in-replay sequence done");

    // Counter saturation: 2^CW + 3 conflicts must leave the counter at all-ones.
    for (int k = 0; k < (1 << CW) + 3; k++) begin
      @(negedge clk);
      drive_conflict();
      @(negedge clk);
      drive_idle();
      if (k == (1 << CW) - 1) begin
        #1;
        chk("sat.at_16", 64'(conflict_cnt), 64'd15);
      end
    end
    @(negedge clk); #1;
    chk("sat.final", 64'(conflict_cnt), 64'd15);
    $display("[TB] saturation sequence done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
